reconfig_sequencer: RTL and testbench

- Drives the FPGA remote-update configuration pins (`cfg_ENA`, `cfg_CBSEL`, `cfg_CONFIG`) for the internal-reconfiguration golden image top.
- Accepts an image-select request and sequences enable, select setup, CONFIG pulse and error watch.
- Retries on `cfg_ERROR`, then falls back to the golden image.
- Sits directly upstream of the configuration pins and reports status to the top (LEDs, `cfg_ERROR_port`).

---
 rtl/recfg_pkg.sv | 28 ++
 rtl/recfg_sync_edge.sv | 28 ++
 rtl/reconfig_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_reconfig_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recfg_pkg.sv
// Shared types and constants for the remote-update reconfiguration sequencer.
//   state_e    : sequencer FSM states
//   status codes, golden image index, and a small max helper for counter sizing
package recfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PULSE = 3'd2,
    WATCH = 3'd3,
    ERR   = 3'd4,
    FAIL  = 3'd5
  } state_e;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_RETRY    = 2'd1;
  localparam logic [1:0] ST_FALLBACK = 2'd2;
  localparam logic [1:0] ST_FAIL     = 2'd3;

  localparam logic [1:0] GOLDEN_IMG = 2'd0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/recfg_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous pin.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   din_i     : asynchronous input
//   level_o   : synchronised level
//   rise_o    : one-cycle pulse on a synchronised rising edge
module recfg_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level
  logic [2:0] sh_q, sh_d;

  assign sh_d = {sh_q[1:0], din_i};

  always_ff @(posedge clk) begin
    if (!rstn) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign level_o = sh_q[1];
  assign rise_o  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/reconfig_sequencer.sv
// Remote-update configuration pin sequencer: enable, image-select setup,
// CONFIG pulse and error watch, with retry and fallback to the golden image.
// Optional build macro RECFG_DEBOUNCE_EN adds a debounced push-button
// request for image 1 on trig_btn; without it trig_btn is ignored.
// Ports:
//   clk, rstn                      : clock, synchronous active-low reset
//   req_valid/req_image/req_ready  : image-select request handshake
//   trig_btn                       : push-button request (macro only)
//   cfg_ERROR                      : asynchronous config-error pin
//   cfg_ENA/cfg_CBSEL/cfg_CONFIG   : configuration block pins
//   busy, status, err_seen         : status to the top level
//   err_clr                        : clears err_seen/status, exits FAIL
//
// state | meaning
// IDLE  | waiting for a request
// ARM   | enable and image select driven, setup time
// PULSE | CONFIG held high
// WATCH | monitoring cfg_ERROR after the pulse
// ERR   | one-cycle retry / fallback / fail decision
// FAIL  | golden image also failed, waiting for err_clr
module reconfig_sequencer #(
  parameter int SETUP_CYC    = 16,
  parameter int PULSE_CYC    = 32,
  parameter int WATCH_CYC    = 1024,
  parameter int MAX_RETRY    = 2,
  parameter int DEBOUNCE_CYC = 65536
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [1:0] req_image,
  output logic       req_ready,
  input  logic       trig_btn,
  input  logic       cfg_ERROR,
  output logic       cfg_ENA,
  output logic [1:0] cfg_CBSEL,
  output logic       cfg_CONFIG,
  output logic       busy,
  output logic [1:0] status,
  output logic       err_seen,
  input  logic       err_clr
);
  import recfg_pkg::*;

  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, WATCH_CYC)) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       status_q, status_d;
  logic             err_seen_q, err_seen_d;

  logic       err_rise, err_lvl_unused;
  logic       req_fire;
  logic [1:0] req_img;

  recfg_sync_edge u_err_sync (
    .clk     (clk),
    .rstn    (rstn),
    .din_i   (cfg_ERROR),
    .level_o (err_lvl_unused),
    .rise_o  (err_rise)
  );

`ifdef RECFG_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC) + 1;

  logic            btn_lvl, btn_rise_unused, btn_press;
  logic            btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  recfg_sync_edge u_btn_sync (
    .clk     (clk),
    .rstn    (rstn),
    .din_i   (trig_btn),
    .level_o (btn_lvl),
    .rise_o  (btn_rise_unused)
  );

  // Debounced level only follows the pin after it has differed for a full window.
  always_comb begin
    btn_db_d  = btn_db_q;
    db_cnt_d  = '0;
    btn_press = 1'b0;
    if (btn_lvl != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        btn_db_d  = btn_lvl;
        btn_press = btn_lvl;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // req_valid wins over a simultaneous button press
  assign req_fire = (state_q == IDLE) && (req_valid || btn_press);
  assign req_img  = req_valid ? req_image : 2'd1;
`else
  logic trig_unused;
  assign trig_unused = trig_btn;
  assign req_fire    = (state_q == IDLE) && req_valid;
  assign req_img     = req_image;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = ARM;
      ARM:     if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = PULSE;
      PULSE:   if (cnt_q == CNT_W'(PULSE_CYC - 1)) state_d = WATCH;
      WATCH: begin
        if (err_rise)                               state_d = ERR;
        else if (cnt_q == CNT_W'(WATCH_CYC - 1))    state_d = IDLE;
      end
      ERR: begin
        if (retry_q < RTY_W'(MAX_RETRY) || tgt_q != GOLDEN_IMG) state_d = ARM;
        else                                                    state_d = FAIL;
      end
      FAIL:    if (err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    cfg_ENA    = 1'b0;
    cfg_CBSEL  = 2'd0;
    cfg_CONFIG = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      FAIL:  busy = 1'b0;
      ARM, WATCH, ERR: begin
        cfg_ENA   = 1'b1;
        cfg_CBSEL = tgt_q;
      end
      PULSE: begin
        cfg_ENA    = 1'b1;
        cfg_CBSEL  = tgt_q;
        cfg_CONFIG = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: phase counter, retry bookkeeping, target image, status, sticky error.
  always_comb begin
    cnt_d    = '0;
    retry_d  = retry_q;
    tgt_d    = tgt_q;
    status_d = err_clr ? ST_OK : status_q;
    if (state_d == state_q && (state_q == ARM || state_q == PULSE || state_q == WATCH))
      cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          tgt_d   = req_img;
          retry_d = '0;
        end
      end
      WATCH: if (state_d == IDLE) status_d = ST_OK;
      ERR: begin
        if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d  = retry_q + RTY_W'(1);
          status_d = ST_RETRY;
        end else if (tgt_q != GOLDEN_IMG) begin
          tgt_d    = GOLDEN_IMG;
          retry_d  = '0;
          status_d = ST_FALLBACK;
        end else begin
          status_d = ST_FAIL;
        end
      end
      default: ;
    endcase
    // a new error edge beats a simultaneous clear
    err_seen_d = err_rise | (err_seen_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      retry_q    <= '0;
      tgt_q      <= GOLDEN_IMG;
      status_q   <= ST_OK;
      err_seen_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      tgt_q      <= tgt_d;
      status_q   <= status_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign status   = status_q;
  assign err_seen = err_seen_q;

endmodule

// File: tb/tb_reconfig_sequencer.sv
// Randomised bench for reconfig_sequencer. Pin activity is recorded as
// run-length segments of {ENA, CBSEL, CONFIG, busy, req_ready, status} and
// compared with segments predicted from the sequencing rules.
module tb_reconfig_sequencer;

  localparam int SETUP = 16;
  localparam int PULSE = 32;
  localparam int WATCH = 1024;
  localparam int MAXR  = 2;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic [1:0] req_image;
  logic       req_ready;
  logic       trig_btn;
  logic       cfg_ERROR;
  logic       cfg_ENA;
  logic [1:0] cfg_CBSEL;
  logic       cfg_CONFIG;
  logic       busy;
  logic [1:0] status;
  logic       err_seen;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] v;
    int         len;
  } seg_t;

  seg_t exp_q[$];
  seg_t obs_q[$];
  int   raise_q[$];
  int   total_len;
  int   ek[8];

  reconfig_sequencer #(
    .SETUP_CYC    (SETUP),
    .PULSE_CYC    (PULSE),
    .WATCH_CYC    (WATCH),
    .MAX_RETRY    (MAXR),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_image  (req_image),
    .req_ready  (req_ready),
    .trig_btn   (trig_btn),
    .cfg_ERROR  (cfg_ERROR),
    .cfg_ENA    (cfg_ENA),
    .cfg_CBSEL  (cfg_CBSEL),
    .cfg_CONFIG (cfg_CONFIG),
    .busy       (busy),
    .status     (status),
    .err_seen   (err_seen),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] pk(input bit ena, input logic [1:0] cb, input bit cf,
                                    input bit bsy, input bit rdy, input logic [1:0] st);
    return {ena, cb, cf, bsy, rdy, st};
  endfunction

  function automatic logic [7:0] obs_now();
    return {cfg_ENA, cfg_CBSEL, cfg_CONFIG, busy, req_ready, status};
  endfunction

  task automatic push_exp(input logic [7:0] v, input int len);
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].v == v)
      exp_q[exp_q.size()-1].len = exp_q[exp_q.size()-1].len + len;
    else
      exp_q.push_back('{v, len});
    total_len = total_len + len;
  endtask

  // Predicted pin segments from handshake onward; ek[a] is the WATCH cycle in
  // which the error pin rises for attempt a (-1 = clean attempt).
  task automatic build_model(input logic [1:0] img, input logic [1:0] st0, input int tail);
    logic [1:0] tgt;
    logic [1:0] st;
    int         retries;
    tgt = img; st = st0; retries = 0;
    exp_q.delete(); raise_q.delete(); total_len = 0;
    for (int a = 0; a < 8; a++) begin
      push_exp(pk(1, tgt, 0, 1, 0, st), SETUP);
      push_exp(pk(1, tgt, 1, 1, 0, st), PULSE);
      if (ek[a] < 0) begin
        push_exp(pk(1, tgt, 0, 1, 0, st), WATCH);
        push_exp(pk(0, 2'd0, 0, 0, 1, 2'd0), tail);
        return;
      end
      raise_q.push_back(total_len + ek[a]);
      // 3 cycles to detect, then the one-cycle decision state
      push_exp(pk(1, tgt, 0, 1, 0, st), ek[a] + 4);
      if (retries < MAXR) begin
        retries++; st = 2'd1;
      end else if (tgt != 2'd0) begin
        tgt = 2'd0; retries = 0; st = 2'd2;
      end else begin
        push_exp(pk(0, 2'd0, 0, 0, 0, 2'd3), tail);
        return;
      end
    end
  endtask

  // Issues a request (called #1 after an edge, DUT idle) and records total_len cycles.
  task automatic run_seq(input logic [1:0] img, input bit noise, input int stray);
    bit         hi;
    logic [7:0] v;
    req_image = img;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    obs_q.delete();
    for (int c = 0; c < total_len; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      v = obs_now();
      if (obs_q.size() > 0 && obs_q[obs_q.size()-1].v == v)
        obs_q[obs_q.size()-1].len = obs_q[obs_q.size()-1].len + 1;
      else
        obs_q.push_back('{v, 1});
      hi = 1'b0;
      foreach (raise_q[i]) if (c == raise_q[i] || c == raise_q[i] + 1) hi = 1'b1;
      if (stray >= 0 && (c == stray || c == stray + 1)) hi = 1'b1;
      cfg_ERROR = hi;
      if (noise && busy) begin
        req_valid = 1'($urandom_range(0, 1));
        req_image = 2'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    cfg_ERROR = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b1; req_image = 2'd3; cfg_ERROR = 1'b0; err_clr = 1'b0; trig_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_now() !== pk(0, 2'd0, 0, 0, 1, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", obs_now(), pk(0, 2'd0, 0, 0, 1, 2'd0));
    end
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_seen got %b want 0", err_seen);
    end
    req_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [1:0] img;
    for (int r = 0; r < 3; r++) begin
      img = 2'($urandom);
      if (r == 0) img = 2'd2;
      foreach (ek[i]) ek[i] = -1;
      build_model(img, 2'd0, 4);
      run_seq(img, 1'b0, -1);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL nominal_segcount img=%0d got %0d want %0d", img, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].v !== exp_q[i].v || obs_q[i].len != exp_q[i].len) begin
          n_fail++;
          $display("FAIL nominal_seg%0d img=%0d got v=%h len=%0d want v=%h len=%0d",
                   i, img, obs_q[i].v, obs_q[i].len, exp_q[i].v, exp_q[i].len);
        end
      end
      n_checks++;
      if (err_seen !== 1'b0) begin
        n_fail++; $display("FAIL nominal_err_seen got %b want 0", err_seen);
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
  endtask

  // Requests while busy must be dropped; an error edge in ARM only sets err_seen.
  task automatic test_busy();
    logic [1:0] img;
    img = 2'($urandom);
    foreach (ek[i]) ek[i] = -1;
    build_model(img, 2'd0, 2);
    run_seq(img, 1'b1, 2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL busy_segcount got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].v !== exp_q[i].v || obs_q[i].len != exp_q[i].len) begin
        n_fail++;
        $display("FAIL busy_seg%0d got v=%h len=%0d want v=%h len=%0d",
                 i, obs_q[i].v, obs_q[i].len, exp_q[i].v, exp_q[i].len);
      end
    end
    n_checks++;
    if (err_seen !== 1'b1) begin
      n_fail++; $display("FAIL busy_err_seen got %b want 1", err_seen);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL busy_err_clr got %b want 0", err_seen);
    end
  endtask

  // Error edge and err_clr in the same cycle: the set wins; IDLE is not left.
  task automatic test_simultaneous();
    cfg_ERROR = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (err_seen !== 1'b1) begin
      n_fail++; $display("FAIL simul_set_wins got %b want 1", err_seen);
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    cfg_ERROR = 1'b0;
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL simul_clear got %b want 0", err_seen);
    end
    n_checks++;
    if (obs_now() !== pk(0, 2'd0, 0, 0, 1, 2'd0)) begin
      n_fail++; $display("FAIL simul_idle got %h want %h", obs_now(), pk(0, 2'd0, 0, 0, 1, 2'd0));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_retry_fallback();
    foreach (ek[i]) ek[i] = -1;
    for (int a = 0; a < 3; a++) ek[a] = $urandom_range(0, 1000);
    build_model(2'd1, 2'd0, 3);
    run_seq(2'd1, 1'b0, -1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fallback_segcount got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].v !== exp_q[i].v || obs_q[i].len != exp_q[i].len) begin
        n_fail++;
        $display("FAIL fallback_seg%0d got v=%h len=%0d want v=%h len=%0d",
                 i, obs_q[i].v, obs_q[i].len, exp_q[i].v, exp_q[i].len);
      end
    end
    n_checks++;
    if (err_seen !== 1'b1) begin
      n_fail++; $display("FAIL fallback_err_seen got %b want 1", err_seen);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_fail();
    logic [1:0] img;
    for (int r = 0; r < 2; r++) begin
      img = (r == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      foreach (ek[i]) ek[i] = $urandom_range(0, 1000);
      build_model(img, 2'd0, 5);
      run_seq(img, 1'b0, -1);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL fail_segcount img=%0d got %0d want %0d", img, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].v !== exp_q[i].v || obs_q[i].len != exp_q[i].len) begin
          n_fail++;
          $display("FAIL fail_seg%0d img=%0d got v=%h len=%0d want v=%h len=%0d",
                   i, img, obs_q[i].v, obs_q[i].len, exp_q[i].v, exp_q[i].len);
        end
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      n_checks++;
      if (obs_now() !== pk(0, 2'd0, 0, 0, 1, 2'd0) || err_seen !== 1'b0) begin
        n_fail++;
        $display("FAIL fail_exit got %h err_seen=%b want %h err_seen=0",
                 obs_now(), err_seen, pk(0, 2'd0, 0, 0, 1, 2'd0));
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    req_image = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (SETUP + 10) @(posedge clk);
    #1;
    n_checks++;
    if (obs_now() !== pk(1, 2'd2, 1, 1, 0, 2'd0)) begin
      n_fail++; $display("FAIL midpulse_pre got %h want %h", obs_now(), pk(1, 2'd2, 1, 1, 0, 2'd0));
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs_now() !== pk(0, 2'd0, 0, 0, 1, 2'd0)) begin
      n_fail++; $display("FAIL midpulse_reset got %h want %h", obs_now(), pk(0, 2'd0, 0, 0, 1, 2'd0));
    end
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_now() !== pk(0, 2'd0, 0, 0, 1, 2'd0)) begin
      n_fail++; $display("FAIL midpulse_stays_idle got %h want %h", obs_now(), pk(0, 2'd0, 0, 0, 1, 2'd0));
    end
  endtask

`ifdef RECFG_DEBOUNCE_EN
  task automatic test_debounce();
    bit seen;
    int n;
    trig_btn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    trig_btn = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (cfg_ENA) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL debounce_glitch got start=%b want 0", seen);
    end
    trig_btn = 1'b1;
    n = 0;
    while (!cfg_ENA && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (cfg_ENA !== 1'b1 || cfg_CBSEL !== 2'd1) begin
      n_fail++; $display("FAIL debounce_press got ena=%b cbsel=%0d want ena=1 cbsel=1", cfg_ENA, cfg_CBSEL);
    end
    n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    trig_btn = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || status !== 2'd0) begin
      n_fail++; $display("FAIL debounce_done got ready=%b status=%0d want ready=1 status=0", req_ready, status);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_image = 2'd0;
    trig_btn = 1'b0; cfg_ERROR = 1'b0; err_clr = 1'b0;
    test_reset();
    test_nominal();
    test_busy();
    test_simultaneous();
    test_retry_fallback();
    test_fail();
    test_reset_mid_pulse();
`ifdef RECFG_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
